// File: rtl/block_collision_engine.sv
// ============================================================================
//  Module      : block_collision_engine
//  Description : Side-scroller player square versus scrolling obstacle blocks.
//                Each frame strobe advances the scroll offset, scans all blocks
//                for horizontal overlap with the square and steps the square
//                up onto, along, or down off the blocks.
//                Optional macro COLLISION_DETECT_EN adds a CRASH state that is
//                entered when a block intrudes into the square from the side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_collision_engine #(
    parameter int NUM_BLOCKS  = 5,
    parameter int COORD_W     = 11,
    parameter int SQUARE_SIZE = 10,
    parameter int STEP        = 10,
    parameter int ORIG_X      = 59,
    parameter int ORIG_Y      = 89,
    localparam int IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          update_screen,
    input  logic [COORD_W-1:0]            load_move_counter,
    input  logic [NUM_BLOCKS*COORD_W-1:0] load_block_x_pos,
    input  logic [NUM_BLOCKS*COORD_W-1:0] load_block_y_pos,
    output logic [COORD_W-1:0]            square_x_pos,
    output logic [COORD_W-1:0]            square_y_pos,
    output logic                          on_block,
    output logic [IDX_W-1:0]              support_index,
    output logic                          collision
);

    localparam logic [2:0] ST_GROUND    = 3'd0;
    localparam logic [2:0] ST_RAISE     = 3'd1;
    localparam logic [2:0] ST_SUPPORTED = 3'd2;
    localparam logic [2:0] ST_FALL      = 3'd3;
`ifdef COLLISION_DETECT_EN
    localparam logic [2:0] ST_CRASH     = 3'd4;
`endif

    localparam logic [COORD_W-1:0] X_LO   = COORD_W'(ORIG_X);
    localparam logic [COORD_W-1:0] X_HI   = COORD_W'(ORIG_X + SQUARE_SIZE - 1);
    localparam logic [COORD_W-1:0] Y_GND  = COORD_W'(ORIG_Y);
    localparam logic [COORD_W-1:0] STEP_N = COORD_W'(STEP);
    localparam logic [COORD_W:0]   STEP_X = (COORD_W+1)'(STEP);
`ifdef COLLISION_DETECT_EN
    localparam logic [COORD_W:0]   SIZE_X = (COORD_W+1)'(SQUARE_SIZE);
`endif

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [COORD_W-1:0]    move;
    logic [COORD_W-1:0]    move_nxt;
    logic [COORD_W-1:0]    y_nxt;
    logic                  on_nxt;
    logic [IDX_W-1:0]      idx_nxt;
    logic                  col_nxt;

    // One position below the square, kept one bit wider so it cannot wrap.
    logic [COORD_W:0]      y_down;
    assign y_down = {1'b0, square_y_pos} + STEP_X;

    logic [NUM_BLOCKS-1:0] overlap;
    logic [NUM_BLOCKS-1:0] level;
    logic [NUM_BLOCKS-1:0] below;
`ifdef COLLISION_DETECT_EN
    logic [NUM_BLOCKS-1:0] intrude;
`endif

    // Per-block scroll and classification against the current square position.
    for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
        logic [COORD_W-1:0] bx;
        logic [COORD_W-1:0] by;
        logic [COORD_W-1:0] sx;
        assign bx         = load_block_x_pos[i*COORD_W +: COORD_W];
        assign by         = load_block_y_pos[i*COORD_W +: COORD_W];
        assign sx         = bx - move;
        assign overlap[i] = (sx >= X_LO) && (sx <= X_HI);
        assign level[i]   = overlap[i] && (by == square_y_pos);
        assign below[i]   = overlap[i] && ({1'b0, by} == y_down);
`ifdef COLLISION_DETECT_EN
        // Strictly inside the square's vertical span, written without subtraction.
        assign intrude[i] = overlap[i] && (by < square_y_pos) &&
                            (({1'b0, by} + SIZE_X) > {1'b0, square_y_pos});
`endif
    end

    logic             any_level;
    logic             any_below;
    logic             latched_ov;
    logic [IDX_W-1:0] level_idx;
    logic [IDX_W-1:0] below_idx;
`ifdef COLLISION_DETECT_EN
    logic             any_intrude;
`endif

    // Lowest-index priority encoders; descending scan lets the lowest hit win.
    always_comb begin
        any_level  = 1'b0;
        any_below  = 1'b0;
        latched_ov = 1'b0;
        level_idx  = '0;
        below_idx  = '0;
`ifdef COLLISION_DETECT_EN
        any_intrude = |intrude;
`endif
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (level[i]) begin
                any_level = 1'b1;
                level_idx = IDX_W'(i);
            end
            if (below[i]) begin
                any_below = 1'b1;
                below_idx = IDX_W'(i);
            end
            if (IDX_W'(i) == support_index) begin
                latched_ov = overlap[i];
            end
        end
    end

    // State and output registers; everything advances only on a frame strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_GROUND;
            move          <= '0;
            square_x_pos  <= X_LO;
            square_y_pos  <= Y_GND;
            on_block      <= 1'b0;
            support_index <= '0;
            collision     <= 1'b0;
        end else if (update_screen) begin
            state         <= state_nxt;
            move          <= move_nxt;
            square_x_pos  <= X_LO;
            square_y_pos  <= y_nxt;
            on_block      <= on_nxt;
            support_index <= idx_nxt;
            collision     <= col_nxt;
        end
    end

    // Next-state selection; an intruding block outranks every other move.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_GROUND: begin
`ifdef COLLISION_DETECT_EN
                if (any_intrude)    state_nxt = ST_CRASH;
                else
`endif
                if (any_level)      state_nxt = ST_RAISE;
            end
            ST_RAISE:               state_nxt = ST_SUPPORTED;
            ST_SUPPORTED: begin
`ifdef COLLISION_DETECT_EN
                if (any_intrude)    state_nxt = ST_CRASH;
                else
`endif
                if (any_level)      state_nxt = ST_RAISE;
                else if (!latched_ov) state_nxt = ST_FALL;
            end
            ST_FALL: begin
`ifdef COLLISION_DETECT_EN
                if (any_intrude)    state_nxt = ST_CRASH;
                else
`endif
                if (any_below)      state_nxt = ST_SUPPORTED;
                else if (y_down >= {1'b0, Y_GND}) state_nxt = ST_GROUND;
                else                state_nxt = ST_FALL;
            end
`ifdef COLLISION_DETECT_EN
            ST_CRASH:               state_nxt = ST_CRASH;
`endif
            default:                state_nxt = ST_GROUND;
        endcase
    end

    // Output/datapath values implied by the chosen transition.
    always_comb begin
        y_nxt    = square_y_pos;
        on_nxt   = on_block;
        idx_nxt  = support_index;
        col_nxt  = collision;
        move_nxt = move + load_move_counter;
`ifdef COLLISION_DETECT_EN
        if (state == ST_CRASH) move_nxt = move;
`endif
        case (state_nxt)
            ST_RAISE: idx_nxt = level_idx;
            ST_SUPPORTED: begin
                on_nxt = 1'b1;
                if (state == ST_RAISE) begin
                    // Clamp at the top edge rather than wrapping.
                    if (square_y_pos >= STEP_N) y_nxt = square_y_pos - STEP_N;
                end else if (state == ST_FALL) begin
                    idx_nxt = below_idx;
                end
            end
            ST_FALL: begin
                on_nxt = 1'b0;
                if (state == ST_FALL) y_nxt = y_down[COORD_W-1:0];
            end
            ST_GROUND: begin
                if (state == ST_FALL) y_nxt = Y_GND;
            end
`ifdef COLLISION_DETECT_EN
            ST_CRASH: col_nxt = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_block_collision_engine.sv
`default_nettype none

module tb_block_collision_engine;

    localparam int NB = 5;
    localparam int CW = 11;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            update_screen = 1'b0;
    logic [CW-1:0]   load_move_counter = '0;
    logic [NB*CW-1:0] bx = '0;
    logic [NB*CW-1:0] by = '0;
    logic [CW-1:0]   square_x_pos;
    logic [CW-1:0]   square_y_pos;
    logic            on_block;
    logic [2:0]      support_index;
    logic            collision;

    int n_cmp = 0;
    int n_err = 0;

    block_collision_engine dut (
        .clock             (clock),
        .reset             (reset),
        .update_screen     (update_screen),
        .load_move_counter (load_move_counter),
        .load_block_x_pos  (bx),
        .load_block_y_pos  (by),
        .square_x_pos      (square_x_pos),
        .square_y_pos      (square_y_pos),
        .on_block          (on_block),
        .support_index     (support_index),
        .collision         (collision)
    );

    always #5 clock = ~clock;

    task automatic set_block(input int i, input int x, input int y);
        bx[i*CW +: CW] = CW'(x);
        by[i*CW +: CW] = CW'(y);
    endtask

    task automatic park();
        for (int i = 0; i < NB; i++) set_block(i, 1000, 500);
    endtask

    task automatic strobe();
        update_screen = 1'b1;
        @(posedge clock); #1;
        update_screen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        load_move_counter = '0;
        park();
    endtask

    task automatic test_reset();
        update_screen = 1'b1;
        load_move_counter = 11'd7;
        set_block(0, 62, 89);
        set_block(1, 60, 85);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        update_screen = 1'b0;
        n_cmp++; if (square_x_pos !== 11'd59) begin n_err++; $display("FAIL reset_x got %0d want 59", square_x_pos); end
        n_cmp++; if (square_y_pos !== 11'd89) begin n_err++; $display("FAIL reset_y got %0d want 89", square_y_pos); end
        n_cmp++; if (on_block !== 1'b0) begin n_err++; $display("FAIL reset_on got %b want 0", on_block); end
        n_cmp++; if (support_index !== 3'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", support_index); end
        n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL reset_col got %b want 0", collision); end
        load_move_counter = '0;
        park();
    endtask

    task automatic test_step_up();
        do_reset();
        set_block(0, 62, 89);
        strobe();
        n_cmp++; if (square_y_pos !== 11'd89 || on_block !== 1'b0) begin n_err++;
            $display("FAIL stepup_detect got y=%0d on=%b want y=89 on=0", square_y_pos, on_block); end
        strobe();
        n_cmp++; if (square_y_pos !== 11'd79 || on_block !== 1'b1 || support_index !== 3'd0) begin n_err++;
            $display("FAIL stepup_raise got y=%0d on=%b idx=%0d want y=79 on=1 idx=0", square_y_pos, on_block, support_index); end
    endtask

    task automatic test_hold();
        do_reset();
        set_block(0, 62, 89);
        idle(3);
        n_cmp++; if (square_y_pos !== 11'd89 || on_block !== 1'b0) begin n_err++;
            $display("FAIL hold_nostrobe got y=%0d on=%b want y=89 on=0", square_y_pos, on_block); end
        park();
        strobe();
        strobe();
        n_cmp++; if (square_y_pos !== 11'd89 || on_block !== 1'b0) begin n_err++;
            $display("FAIL hold_unsampled got y=%0d on=%b want y=89 on=0", square_y_pos, on_block); end
    endtask

    task automatic test_scroll_off();
        do_reset();
        set_block(0, 62, 89);
        strobe();
        strobe();
        load_move_counter = 11'd20;
        strobe();
        load_move_counter = 11'd0;
        n_cmp++; if (square_y_pos !== 11'd79 || on_block !== 1'b1) begin n_err++;
            $display("FAIL scroll_still got y=%0d on=%b want y=79 on=1", square_y_pos, on_block); end
        strobe();
        n_cmp++; if (square_y_pos !== 11'd79 || on_block !== 1'b0) begin n_err++;
            $display("FAIL scroll_fall got y=%0d on=%b want y=79 on=0", square_y_pos, on_block); end
        strobe();
        n_cmp++; if (square_y_pos !== 11'd89 || on_block !== 1'b0) begin n_err++;
            $display("FAIL scroll_ground got y=%0d on=%b want y=89 on=0", square_y_pos, on_block); end
        strobe();
        n_cmp++; if (square_y_pos !== 11'd89) begin n_err++;
            $display("FAIL scroll_stay got y=%0d want 89", square_y_pos); end
    endtask

    task automatic test_tie();
        do_reset();
        set_block(1, 60, 89);
        set_block(3, 65, 89);
        strobe();
        n_cmp++; if (support_index !== 3'd1) begin n_err++;
            $display("FAIL tie_latch got idx=%0d want 1", support_index); end
        strobe();
        n_cmp++; if (square_y_pos !== 11'd79 || on_block !== 1'b1 || support_index !== 3'd1) begin n_err++;
            $display("FAIL tie_raise got y=%0d on=%b idx=%0d want y=79 on=1 idx=1", square_y_pos, on_block, support_index); end
    endtask

    task automatic test_overlap_edges();
        int xs [4] = '{58, 59, 68, 69};
        int ys [4] = '{89, 79, 79, 89};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            set_block(2, xs[k], 89);
            strobe();
            strobe();
            n_cmp++; if (square_y_pos !== CW'(ys[k])) begin n_err++;
                $display("FAIL edge_x%0d got y=%0d want %0d", xs[k], square_y_pos, ys[k]); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_block(0, 5, 89);
        load_move_counter = 11'd2040;
        strobe();
        load_move_counter = 11'd10;
        strobe();
        load_move_counter = 11'd0;
        strobe();
        strobe();
        n_cmp++; if (square_y_pos !== 11'd89 || on_block !== 1'b0) begin n_err++;
            $display("FAIL wrap_sx3 got y=%0d on=%b want y=89 on=0", square_y_pos, on_block); end
        set_block(0, 64, 89);
        strobe();
        strobe();
        n_cmp++; if (square_y_pos !== 11'd79 || on_block !== 1'b1) begin n_err++;
            $display("FAIL wrap_sx62 got y=%0d on=%b want y=79 on=1", square_y_pos, on_block); end
    endtask

    task automatic test_land();
        do_reset();
        set_block(0, 62, 89);
        strobe();
        strobe();
        set_block(0, 1000, 500);
        set_block(1, 64, 89);
        strobe();
        n_cmp++; if (on_block !== 1'b0 || square_y_pos !== 11'd79) begin n_err++;
            $display("FAIL land_fall got y=%0d on=%b want y=79 on=0", square_y_pos, on_block); end
        strobe();
        n_cmp++; if (on_block !== 1'b1 || square_y_pos !== 11'd79 || support_index !== 3'd1) begin n_err++;
            $display("FAIL land_catch got y=%0d on=%b idx=%0d want y=79 on=1 idx=1", square_y_pos, on_block, support_index); end
    endtask

    task automatic test_stair_top();
        int ey;
        do_reset();
        ey = 89;
        for (int k = 0; k < 10; k++) begin
            set_block(0, 62, ey);
            strobe();
            strobe();
            ey = (ey >= 10) ? ey - 10 : ey;
            n_cmp++; if (square_y_pos !== CW'(ey) || on_block !== 1'b1) begin n_err++;
                $display("FAIL stair_%0d got y=%0d on=%b want y=%0d on=1", k, square_y_pos, on_block, ey); end
        end
    endtask

    task automatic test_crash();
        do_reset();
        set_block(0, 60, 85);
        strobe();
`ifdef COLLISION_DETECT_EN
        n_cmp++; if (collision !== 1'b1 || square_y_pos !== 11'd89) begin n_err++;
            $display("FAIL crash_set got col=%b y=%0d want col=1 y=89", collision, square_y_pos); end
        load_move_counter = 11'd33;
        set_block(0, 62, 89);
        repeat (10) strobe();
        load_move_counter = 11'd0;
        n_cmp++; if (collision !== 1'b1 || square_y_pos !== 11'd89 || on_block !== 1'b0 || support_index !== 3'd0) begin n_err++;
            $display("FAIL crash_frozen got col=%b y=%0d on=%b idx=%0d want col=1 y=89 on=0 idx=0",
                     collision, square_y_pos, on_block, support_index); end
        do_reset();
        n_cmp++; if (collision !== 1'b0) begin n_err++;
            $display("FAIL crash_clear got col=%b want 0", collision); end
`else
        n_cmp++; if (collision !== 1'b0 || square_y_pos !== 11'd89) begin n_err++;
            $display("FAIL nocrash got col=%b y=%0d want col=0 y=89", collision, square_y_pos); end
`endif
    endtask

    initial begin
        park();
        idle(2);
        test_reset();
        test_step_up();
        test_hold();
        test_scroll_off();
        test_tie();
        test_overlap_edges();
        test_wrap();
        test_land();
        test_stair_top();
        test_crash();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
